// File: rtl/flex_down_counter_if.sv
// rtl/flex_down_counter_if.sv - control/status bundle for flex_down_counter
//
// Purpose: groups the countdown controls and status outputs of flex_down_counter.
// Ports (through the modports):
//   clear, load, load_val, count_enable : controls, master -> slave
//   count_out, zero_flag, busy,
//   expire_pulse                        : status, slave -> master
interface flex_down_counter_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    zero_flag;
  logic                    busy;
  logic                    expire_pulse;

  modport master (
    output clear, load, load_val, count_enable,
    input  count_out, zero_flag, busy, expire_pulse
  );

  modport slave (
    input  clear, load, load_val, count_enable,
    output count_out, zero_flag, busy, expire_pulse
  );
endinterface

// File: rtl/flex_down_counter.sv
// rtl/flex_down_counter.sv - loadable down-counter/timer with expiry strobe
//
// Purpose: preloads a count, decrements it once per enabled cycle and strobes
// expire_pulse on the step from 1 to 0. Used for bit-period, byte-length and
// timeout countdowns.
// Ports:
//   clk               system clock, all state updates on posedge
//   rst               synchronous active-high reset
//   bus.clear         abort to IDLE with count 0
//   bus.load          capture bus.load_val and start the countdown
//   bus.load_val      start value
//   bus.count_enable  decrement strobe
//   bus.count_out     registered current count
//   bus.zero_flag     registered, 1 iff count_out == 0
//   bus.busy          1 while counting (RUN)
//   bus.expire_pulse  registered one-cycle strobe on the terminal step
// Build option: AUTO_RELOAD_EN - when defined, the terminal step reloads the
// last loaded value and keeps running, giving a periodic expire_pulse.
module flex_down_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  flex_down_counter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

  state_t                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    zero_q, zero_d;
  logic                    expire_q, expire_d;
`ifdef AUTO_RELOAD_EN
  logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    expire_d = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.clear) begin
      state_d = IDLE;
      count_d = CNT_ZERO;
`ifdef AUTO_RELOAD_EN
      reload_d = CNT_ZERO;
`endif
    end else if (bus.load) begin
      // Loading zero is an immediate no-op countdown: no RUN, no strobe.
      count_d = bus.load_val;
      state_d = (bus.load_val != CNT_ZERO) ? RUN : IDLE;
`ifdef AUTO_RELOAD_EN
      reload_d = bus.load_val;
`endif
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.count_enable) begin
            if (count_q > CNT_ONE) begin
              count_d = count_q - CNT_ONE;
            end else begin
              // Terminal step; count_q <= 1 also guards against ever wrapping.
              expire_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = CNT_ZERO;
              state_d = DONE;
`endif
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // Flag follows the next count so it lines up with count_out.
    zero_d = (count_d == CNT_ZERO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= CNT_ZERO;
      zero_q   <= 1'b1;
      expire_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= CNT_ZERO;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      zero_q   <= zero_d;
      expire_q <= expire_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.count_out    = count_q;
  assign bus.zero_flag    = zero_q;
  assign bus.busy         = (state_q == RUN);
  assign bus.expire_pulse = expire_q;
endmodule
